// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead add/sub datapath:
// default widths, the group propagate/generate pair and the group carry step.
package cla_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int GROUP_DEF  = 4;
  localparam int NGROUP_DEF = WIDTH_DEF / GROUP_DEF;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Carry out of a group given its P/G and the carry into it.
  function automatic logic group_carry(input pg_t pg, input logic cin);
    return pg.g | (pg.p & cin);
  endfunction

endpackage

// File: rtl/cla_group_pg.sv
// Group propagate/generate: P is the AND of the bit propagates, G is the
// lookahead OR-chain of generates walked from LSB to MSB.
module cla_group_pg
  import cla_pkg::*;
#(
  parameter int GROUP = GROUP_DEF
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  output pg_t              pg
);

  logic grp_g;

  always_comb begin
    grp_g = g[0];
    for (int i = 1; i < GROUP; i++)
      grp_g = g[i] | (p[i] & grp_g);
  end

  assign pg.p = &p;
  assign pg.g = grp_g;

endmodule

// File: rtl/cla_sub_pipe.sv
// Two-stage carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage 1 registers bit and group P/G; stage 2 resolves carries and flags.
module cla_sub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GROUP = GROUP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_c,
  output logic             out_ovf
);

  // WIDTH must be a multiple of GROUP.
  localparam int NGROUP = WIDTH / GROUP;

  logic s1_valid, s2_valid;
  logic s1_load, s2_load;

  // ---------------- flow control ----------------
  assign in_ready = !s1_valid || !s2_valid || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid && (!s2_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_load)      s1_valid <= 1'b1;
      else if (s2_load) s1_valid <= 1'b0;
      if (s2_load)        s2_valid <= 1'b1;
      else if (out_ready) s2_valid <= 1'b0;
    end
  end

  // ---------------- stage 1: operand conditioning and P/G ----------------
  logic [WIDTH-1:0]  b_x, p_in, g_in;
  pg_t [NGROUP-1:0]  grp_in;

  assign b_x  = in_sub ? ~in_b : in_b;
  assign p_in = in_a ^ b_x;
  assign g_in = in_a & b_x;

  for (genvar k = 0; k < NGROUP; k++) begin : g_grp
    cla_group_pg #(.GROUP(GROUP)) u_pg (
      .p  (p_in[k*GROUP +: GROUP]),
      .g  (g_in[k*GROUP +: GROUP]),
      .pg (grp_in[k])
    );
  end

  logic [WIDTH-1:0] s1_p, s1_g;
  pg_t [NGROUP-1:0] s1_grp;
  logic             s1_cin, s1_sub, s1_amsb, s1_bmsb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p    <= '0;
      s1_g    <= '0;
      s1_grp  <= '0;
      s1_cin  <= 1'b0;
      s1_sub  <= 1'b0;
      s1_amsb <= 1'b0;
      s1_bmsb <= 1'b0;
    end else if (s1_load) begin
      s1_p    <= p_in;
      s1_g    <= g_in;
      s1_grp  <= grp_in;
      s1_cin  <= in_sub;
      s1_sub  <= in_sub;
      s1_amsb <= in_a[WIDTH-1];
      s1_bmsb <= b_x[WIDTH-1];
    end
  end

  // ---------------- stage 2: carry resolution ----------------
  logic [NGROUP:0]   gc;
  logic [WIDTH-1:0]  c, res;
  // Group-MSB generates only matter through the registered group G.
  logic [NGROUP-1:0] unused_g_top;

  always_comb begin
    gc           = '0;
    c            = '0;
    unused_g_top = '0;
    gc[0]        = s1_cin;
    for (int k = 0; k < NGROUP; k++) begin
      gc[k+1]      = group_carry(s1_grp[k], gc[k]);
      c[k*GROUP]   = gc[k];
      for (int i = 1; i < GROUP; i++)
        c[k*GROUP+i] = s1_g[k*GROUP+i-1] | (s1_p[k*GROUP+i-1] & c[k*GROUP+i-1]);
      unused_g_top[k] = s1_g[k*GROUP+GROUP-1];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_sum
    assign res[i] = s1_p[i] ^ c[i];
  end

  logic [WIDTH-1:0] s2_res;
  logic             s2_c, s2_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_res <= '0;
      s2_c   <= 1'b0;
      s2_ovf <= 1'b0;
    end else if (s2_load) begin
      s2_res <= res;
      s2_c   <= s1_sub ? ~gc[NGROUP] : gc[NGROUP];
      s2_ovf <= (s1_amsb ^ s1_bmsb ^ 1'b1) & (res[WIDTH-1] ^ s1_amsb);
    end
  end

  assign out_valid = s2_valid;
  assign out_res   = s2_res;
  assign out_c     = s2_c;
  assign out_ovf   = s2_ovf;

  // Producers must hold a stalled request steady until it is taken.
  a_in_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && !in_ready) |=> (in_valid && $stable({in_a, in_b, in_sub})));

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Scoreboard bench for cla_sub_pipe: accepted ops push a reference result,
// output transfers pop and compare; scenario tasks add timing/flow checks.
module tb_cla_sub_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_res;
  logic         out_c;
  logic         out_ovf;

  always #5 clk = ~clk;

  cla_sub_pipe #(.WIDTH(W), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_c(out_c), .out_ovf(out_ovf)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;

  // Reference: plain integer arithmetic on W+1 bits, signed overflow by sign rules.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0] full;
    exp_t       e;
    if (sub) full = {1'b0, a} - {1'b0, b};
    else     full = {1'b0, a} + {1'b0, b};
    e.res = full[W-1:0];
    e.c   = full[W];
    if (sub) e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
    else     e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        n_out++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_spurious: got res=%h c=%b ovf=%b, required no output", out_res, out_c, out_ovf);
        end else begin
          e = sb.pop_front();
          if ({out_res, out_c, out_ovf} !== e) begin
            n_bad++;
            $display("FAIL sb_result: got res=%h c=%b ovf=%b, required res=%h c=%b ovf=%b",
                     out_res, out_c, out_ovf, e.res, e.c, e.ovf);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_sub));
    end
  end

  localparam logic [W-1:0] DA [8] = '{16'h0005, 16'h0003, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h1234, 16'h0000};
  localparam logic [W-1:0] DB [8] = '{16'h0003, 16'h0005, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h1234, 16'h0001};
  localparam logic         DS [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic [W-1:0] DR [8] = '{16'h0002, 16'hFFFE, 16'h7FFF, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'hFFFF};
  localparam logic         DC [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic         DV [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, out_res, out_c, out_ovf} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b res=%h c=%b ovf=%b, required all 0", out_valid, out_res, out_c, out_ovf);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    for (int i = 0; i < 8; i++) begin
      in_a = DA[i]; in_b = DB[i]; in_sub = DS[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL dir_early[%0d]: out_valid=%b one cycle after accept, required 0", i, out_valid);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_res !== DR[i] || out_c !== DC[i] || out_ovf !== DV[i]) begin
        n_bad++;
        $display("FAIL dir_result[%0d]: got v=%b res=%h c=%b ovf=%b, required v=1 res=%h c=%b ovf=%b",
                 i, out_valid, out_res, out_c, out_ovf, DR[i], DC[i], DV[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ra [8];
    logic [W-1:0] rb [8];
    logic         rs [8];
    int cnt = 0, first = -1, last = -1, rdy_bad = 0;
    for (int i = 0; i < 8; i++) begin
      ra[i] = W'($urandom); rb[i] = W'($urandom); rs[i] = 1'($urandom);
    end
    ra[2] = 16'h8000; rb[2] = 16'h7FFF; rs[2] = 1'b1;
    out_ready = 1'b1;
    in_a = ra[0]; in_b = rb[0]; in_sub = rs[0]; in_valid = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (in_valid && !in_ready) rdy_bad++;
      @(posedge clk); #1;
      if (out_valid) begin
        cnt++;
        if (first < 0) first = k;
        last = k;
      end
      if (k + 1 < 8) begin
        in_a = ra[k+1]; in_b = rb[k+1]; in_sub = rs[k+1];
      end else in_valid = 1'b0;
    end
    n_cmp++;
    if (cnt != 8 || first != 1 || last != 8 || rdy_bad != 0) begin
      n_bad++;
      $display("FAIL b2b_stream: got count=%0d first=%0d last=%0d stalls=%0d, required 8/1/8/0", cnt, first, last, rdy_bad);
    end
  endtask

  task automatic test_backpressure();
    exp_t ea;
    int   n0;
    n0 = n_out;
    out_ready = 1'b0;
    in_a = 16'h1111; in_b = 16'h0222; in_sub = 1'b1; in_valid = 1'b1;
    ea = model(16'h1111, 16'h0222, 1'b1);
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_ready1: got in_ready=%b after 1 accept, required 1", in_ready);
    end
    in_a = 16'h4000; in_b = 16'h4000; in_sub = 1'b0;
    @(posedge clk); #1;
    in_a = 16'h0000; in_b = 16'h0001; in_sub = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_full[%0d]: got in_ready=%b out_valid=%b, required 0/1", k, in_ready, out_valid);
      end
      if (k < 2) begin @(posedge clk); #1; end
    end
    n_cmp++;
    if (out_res !== ea.res || out_c !== ea.c || sb.size() != 2) begin
      n_bad++;
      $display("FAIL bp_hold: got res=%h c=%b accepted=%0d, required res=%h c=%b accepted=2",
               out_res, out_c, sb.size(), ea.res, ea.c);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (n_out - n0 != 3 || sb.size() != 0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_drain: got outputs=%0d pending=%0d out_valid=%b, required 3/0/0", n_out - n0, sb.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    out_ready = 1'b0;
    in_a = 16'h00AA; in_b = 16'h0055; in_sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 16'h0F0F; in_b = 16'h00F0; in_sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || sb.size() != 2) begin
      n_bad++;
      $display("FAIL rm_inflight: got out_valid=%b accepted=%0d, required 1/2", out_valid, sb.size());
    end
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_clear: got out_valid=%b during reset, required 0", out_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rm_ready: got in_ready=%b after release, required 1", in_ready);
    end
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    n_cmp++;
    if (stale != 0) begin
      n_bad++;
      $display("FAIL rm_stale: got %0d stale output cycles, required 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    repeat (3) begin @(posedge clk); #1; end
    test_backpressure();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d undelivered results, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cla_sub_pipe.md
Name: cla_sub_pipe

Overview:
- Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes on both sides.
- Subtract mode is the primary use: it recovers an operand from a finalized sum, computing a - b as a + ~b + 1 with the grouped CLA carry network.
- The final result bit is p ^ c, matching the codebase's CLA sum finalization.
- Sits between operand producers and result consumers in the datapath; it absorbs downstream stalls without dropping or reordering transactions.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of GROUP.
- GROUP, 4, bits per lookahead group.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and mode present.
- in_ready  output  1  block accepts this cycle.
- in_a  input  WIDTH  minuend / addend A.
- in_b  input  WIDTH  subtrahend / addend B.
- in_sub  input  1  1 = a - b, 0 = a + b.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts this cycle.
- out_res  output  WIDTH  result.
- out_c  output  1  carry-out (add) or borrow (sub; borrow = ~carry-out).
- out_ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset: asserting rst_n low immediately clears s1_valid and s2_valid. out_valid, out_res, out_c and out_ovf all read 0. in_ready reads 1 once rst_n is high.
- Transfer rules: input transfer happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready. Payload must stay stable while valid is high and ready is low (checked by assertion on the input side; guaranteed on the output side).
- Stage 1, on accept: b' = in_sub ? ~in_b : in_b, and cin = in_sub.
  - Register bitwise p = a ^ b' and g = a & b'.
  - Register per-group P (AND of p) and G (lookahead OR-chain of g/p).
  - Register cin, in_sub, a_msb, b_msb.
- Stage 2: compute group carries from the registered P/G and cin, then ripple-lookahead within each group.
  - res = p ^ c.
  - cout = carry out of the MSB group.
  - out_c = in_sub ? ~cout : cout.
  - out_ovf = (a_msb ^ b'_msb ^ 1) & (res_msb ^ a_msb), where b'_msb is the post-inversion bit.
- Latency: an accept in cycle N gives out_valid in cycle N+2 when no stall.
- Throughput: 1 transaction per cycle while out_ready is high.
- Flow control:
  - s2 loads when s1_valid && (!s2_valid || out_ready).
  - s1 loads when in_valid && in_ready.
  - in_ready = !s1_valid || (!s2_valid || out_ready), i.e. combinational in out_ready.
  - Capacity is 2 transactions. With out_ready held low, at most 2 accepts occur, then in_ready = 0.
- Simultaneous events:
  - Accept and output transfer in the same cycle: both stages advance and no bubble is inserted.
  - s1 emptying into s2 while a new input is accepted in the same cycle: legal.
- Boundaries:
  - 0 - 0 gives res 0, out_c 0.
  - a - a gives 0, borrow 0.
  - 0 - 1 gives all-ones, borrow 1.
  - MSB wrap follows two's-complement modulo 2^WIDTH.
- Reset mid-operation: in-flight transactions are discarded and no partial result is emitted after release.
- No X propagation: when a stage is invalid, its data registers hold their last value. The value of outputs while out_valid = 0 is don't-care beyond reset.

Decomposition:
- Shared package cla_pkg holds:
  - the WIDTH/GROUP defaults;
  - NGROUP = WIDTH/GROUP;
  - a pg_t struct {p, g} for group signals;
  - a function for group carry lookahead.
- One sub-module, cla_group_pg: per-group P/G generation from p/g vectors, instantiated NGROUP times in stage 1.
- The final p ^ c uses the existing sum cell per bit.

Test Plan:
- Sub 0x0005 - 0x0003, out_ready = 1 → out_res 0x0002, out_c 0, out_ovf 0, out_valid exactly 2 cycles after accept.
- Sub 0x0003 - 0x0005 → 0xFFFE, out_c 1 (borrow), ovf 0. Sub 0x8000 - 0x0001 → 0x7FFF, out_c 0, ovf 1.
- Add 0xFFFF + 0x0001 → 0x0000, out_c 1, ovf 0. Add 0x7FFF + 0x0001 → 0x8000, out_c 0, ovf 1.
- Back-to-back stream of 8 mixed ops with out_ready = 1 → one result per cycle, order preserved, values match reference model.
- out_ready = 0, in_valid held high with 3 distinct ops:
  - in_ready drops after 2 accepts and the 3rd stays pending;
  - releasing out_ready drains all 3 in order, with no loss or duplication.
- 2 ops in flight, pull rst_n low for 1 cycle → out_valid 0 immediately, in_ready 1 after release, no stale results emitted.
